// File: rtl/addr_map_cfg.sv
`default_nettype none
// ============================================================================
// Module  : addr_map_cfg
// Brief   : Shadow/active rule map with serial validation and atomic commit
//           for the dynamic address decoder.
// Revision: 1.0 - initial release
// ============================================================================
module addr_map_cfg #(
    parameter int unsigned NoIndices    = 32'd2,
    parameter int unsigned NoRules      = 32'd4,
    parameter int unsigned AddrWidth    = 32'd32,
    parameter bit          Napot        = 1'b0,
    parameter int unsigned RuleSelWidth = (NoRules > 32'd1) ? $clog2(NoRules) : 32'd1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   wr_valid_i,
    output logic                                   wr_ready_o,
    input  logic [RuleSelWidth-1:0]                wr_sel_i,
    input  logic [31:0]                            wr_idx_i,
    input  logic [AddrWidth-1:0]                   wr_start_i,
    input  logic [AddrWidth-1:0]                   wr_end_i,
    output logic                                   wr_error_o,
    input  logic                                   commit_valid_i,
    output logic                                   commit_ready_o,
    output logic                                   commit_done_o,
    output logic                                   commit_error_o,
    output logic [RuleSelWidth-1:0]                err_rule_o,
    output logic                                   map_valid_o,
    output logic [NoRules*(32+2*AddrWidth)-1:0]    addr_map_o,
    output logic                                   config_ongoing_o
);

    localparam int unsigned c_RULE_W = 32 + 2 * AddrWidth;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [RuleSelWidth-1:0] r_cnt;
    logic [c_RULE_W-1:0]     r_shadow [NoRules];
    logic [c_RULE_W-1:0]     r_active [NoRules];
    logic                    r_wr_error;
    logic                    r_commit_done;
    logic                    r_commit_error;
    logic [RuleSelWidth-1:0] r_err_rule;
    logic                    r_map_valid;
    logic                    r_ongoing;

    logic [c_RULE_W-1:0]     w_rule;
    logic [31:0]             w_rule_idx;
    logic [AddrWidth-1:0]    w_rule_start;
    logic [AddrWidth-1:0]    w_rule_end;
    logic                    w_pass;
    logic                    w_last;
    logic                    w_sel_oob;

    assign w_rule       = r_shadow[r_cnt];
    assign w_rule_idx   = w_rule[c_RULE_W-1 -: 32];
    assign w_rule_start = w_rule[2*AddrWidth-1 -: AddrWidth];
    assign w_rule_end   = w_rule[AddrWidth-1:0];
    // end == 0 marks an open-ended range and is always accepted
    assign w_pass       = (w_rule_idx < NoIndices) &&
                          (Napot || (w_rule_start < w_rule_end) || (w_rule_end == '0));
    assign w_last       = (32'(r_cnt) == (NoRules - 32'd1));
    assign w_sel_oob    = (32'(wr_sel_i) >= NoRules);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_wr_error     <= 1'b0;
            r_commit_done  <= 1'b0;
            r_commit_error <= 1'b0;
            r_err_rule     <= '0;
            r_map_valid    <= 1'b0;
            r_ongoing      <= 1'b0;
            for (int unsigned i = 0; i < NoRules; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_wr_error     <= 1'b0;
            r_commit_done  <= 1'b0;
            r_commit_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // write lands on the same edge a commit is accepted, so it is included
                    if (wr_valid_i) begin
                        if (w_sel_oob) begin
                            r_wr_error <= 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < NoRules; i++) begin
                                if (wr_sel_i == RuleSelWidth'(i)) begin
                                    r_shadow[i] <= {wr_idx_i, wr_start_i, wr_end_i};
                                end
                            end
                        end
                    end
                    if (commit_valid_i) begin
                        r_state   <= ST_CHECK;
                        r_cnt     <= '0;
                        r_ongoing <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!w_pass) begin
                        r_state        <= ST_IDLE;
                        r_err_rule     <= r_cnt;
                        r_commit_error <= 1'b1;
                        r_ongoing      <= 1'b0;
                    end else if (w_last) begin
                        r_state <= ST_SWAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SWAP: begin
                    for (int unsigned i = 0; i < NoRules; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_map_valid   <= 1'b1;
                    r_commit_done <= 1'b1;
                    r_ongoing     <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NoRules; g++) begin : g_map
            assign addr_map_o[g*c_RULE_W +: c_RULE_W] = r_active[g];
        end
    endgenerate

    assign wr_ready_o       = (r_state == ST_IDLE);
    assign commit_ready_o   = (r_state == ST_IDLE);
    assign wr_error_o       = r_wr_error;
    assign commit_done_o    = r_commit_done;
    assign commit_error_o   = r_commit_error;
    assign err_rule_o       = r_err_rule;
    assign map_valid_o      = r_map_valid;
    assign config_ongoing_o = r_ongoing;

endmodule
`default_nettype wire

// File: tb/tb_addr_map_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_addr_map_cfg
// Brief   : Self-checking bench; two instances (range check / NAPOT) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_addr_map_cfg;

    localparam int unsigned NI = 2;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned SW = 2;
    localparam int unsigned RW = 32 + 2 * AW;
    localparam int unsigned MW = NR * RW;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic [SW-1:0] wr_sel;
    logic [31:0]   wr_idx;
    logic [AW-1:0] wr_start;
    logic [AW-1:0] wr_end;
    logic          commit_valid;

    logic          wr_ready [2];
    logic          wr_error [2];
    logic          commit_ready [2];
    logic          commit_done [2];
    logic          commit_error [2];
    logic [SW-1:0] err_rule [2];
    logic          map_valid [2];
    logic [MW-1:0] addr_map [2];
    logic          ongoing [2];

    // reference model: shadow rules as plain fields, active maps per instance
    logic [31:0]   m_idx [NR];
    logic [AW-1:0] m_st [NR];
    logic [AW-1:0] m_en [NR];
    logic [MW-1:0] m_map [2];
    logic          m_valid [2];
    logic [SW-1:0] m_err [2];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [SW-1:0] sel;
        logic [31:0]   idx;
        logic [AW-1:0] st;
        logic [AW-1:0] en;
        bit            same;
        int            exp_a;
        int            exp_b;
    } vec_t;

    vec_t tab [10];

    addr_map_cfg #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(1'b0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[0]), .wr_sel_i(wr_sel),
        .wr_idx_i(wr_idx), .wr_start_i(wr_start), .wr_end_i(wr_end), .wr_error_o(wr_error[0]),
        .commit_valid_i(commit_valid), .commit_ready_o(commit_ready[0]),
        .commit_done_o(commit_done[0]), .commit_error_o(commit_error[0]),
        .err_rule_o(err_rule[0]), .map_valid_o(map_valid[0]),
        .addr_map_o(addr_map[0]), .config_ongoing_o(ongoing[0])
    );

    addr_map_cfg #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(1'b1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready[1]), .wr_sel_i(wr_sel),
        .wr_idx_i(wr_idx), .wr_start_i(wr_start), .wr_end_i(wr_end), .wr_error_o(wr_error[1]),
        .commit_valid_i(commit_valid), .commit_ready_o(commit_ready[1]),
        .commit_done_o(commit_done[1]), .commit_error_o(commit_error[1]),
        .err_rule_o(err_rule[1]), .map_valid_o(map_valid[1]),
        .addr_map_o(addr_map[1]), .config_ongoing_o(ongoing[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input int inst, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %b expected %b", name, inst, $time, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input int inst, input logic [MW-1:0] act,
                         input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] shadow_map();
        logic [MW-1:0] r;
        r = '0;
        for (int s = 0; s < NR; s++) r[s*RW +: RW] = {m_idx[s], m_st[s], m_en[s]};
        return r;
    endfunction

    function automatic int first_fail(input bit napot);
        for (int s = 0; s < NR; s++) begin
            if (!((m_idx[s] < NI) && (napot || (m_st[s] < m_en[s]) || (m_en[s] == '0))))
                return s;
        end
        return -1;
    endfunction

    task automatic model_write(input logic [SW-1:0] sel, input logic [31:0] idx,
                               input logic [AW-1:0] st, input logic [AW-1:0] en);
        if (int'(sel) < NR) begin
            m_idx[sel] = idx;
            m_st[sel]  = st;
            m_en[sel]  = en;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NR; s++) begin
            m_idx[s] = '0;
            m_st[s]  = '0;
            m_en[s]  = '0;
        end
        for (int i = 0; i < 2; i++) begin
            m_map[i]   = '0;
            m_valid[i] = 1'b0;
            m_err[i]   = '0;
        end
    endtask

    task automatic check_inst(input int i, input bit ong, input bit done, input bit err,
                              input bit rdy, input bit wrerr);
        chk1("config_ongoing", i, ongoing[i], ong);
        chk1("commit_done", i, commit_done[i], done);
        chk1("commit_error", i, commit_error[i], err);
        chk1("wr_ready", i, wr_ready[i], rdy);
        chk1("commit_ready", i, commit_ready[i], rdy);
        chk1("wr_error", i, wr_error[i], wrerr);
        chk1("map_valid", i, map_valid[i], m_valid[i]);
        chk_w("err_rule", i, MW'(err_rule[i]), MW'(m_err[i]));
        chk_w("addr_map", i, addr_map[i], m_map[i]);
    endtask

    task automatic do_write(input logic [SW-1:0] sel, input logic [31:0] idx,
                            input logic [AW-1:0] st, input logic [AW-1:0] en);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_idx   = idx;
        wr_start = st;
        wr_end   = en;
        for (int i = 0; i < 2; i++) chk1("wr_ready_idle", i, wr_ready[i], 1'b1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        for (int i = 0; i < 2; i++) chk1("wr_error_pulse", i, wr_error[i], int'(sel) >= NR);
        model_write(sel, idx, st, en);
    endtask

    // exp_* = failing slot, -1 for success, -2 to take it from the model
    task automatic do_commit(input bit same, input bit hold, input logic [SW-1:0] sel,
                             input logic [31:0] idx, input logic [AW-1:0] st,
                             input logic [AW-1:0] en, input int exp_a, input int exp_b);
        int ex [2];
        int fin [2];
        int last;
        @(negedge clk);
        commit_valid = 1'b1;
        if (same) begin
            wr_valid = 1'b1;
            wr_sel   = sel;
            wr_idx   = idx;
            wr_start = st;
            wr_end   = en;
        end
        for (int i = 0; i < 2; i++) chk1("commit_ready_idle", i, commit_ready[i], 1'b1);
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        wr_valid     = 1'b0;
        if (same) model_write(sel, idx, st, en);
        if (hold) begin
            wr_valid = 1'b1;
            wr_sel   = sel;
            wr_idx   = idx;
            wr_start = st;
            wr_end   = en;
        end
        ex[0] = (exp_a == -2) ? first_fail(1'b0) : exp_a;
        ex[1] = (exp_b == -2) ? first_fail(1'b1) : exp_b;
        for (int i = 0; i < 2; i++) fin[i] = (ex[i] < 0) ? int'(NR) + 2 : ex[i] + 2;
        last = (fin[0] > fin[1]) ? fin[0] : fin[1];
        for (int c = 1; c <= last; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 2; i++) begin
                if (c == fin[i]) begin
                    if (ex[i] < 0) begin
                        m_map[i]   = shadow_map();
                        m_valid[i] = 1'b1;
                    end else begin
                        m_err[i] = SW'(ex[i]);
                    end
                end
                check_inst(i, c < fin[i], (c == fin[i]) && (ex[i] < 0),
                           (c == fin[i]) && (ex[i] >= 0), c >= fin[i],
                           (c == 1) && same && (int'(sel) >= NR));
            end
        end
    endtask

    initial begin
        tab[0] = '{sel: 2'd0, idx: 32'd1, st: 16'h1000, en: 16'h2000, same: 1'b0, exp_a: -1, exp_b: -1};
        tab[1] = '{sel: 2'd1, idx: 32'd0, st: 16'h2000, en: 16'h0000, same: 1'b0, exp_a: -1, exp_b: -1};
        tab[2] = '{sel: 2'd1, idx: 32'd2, st: 16'h0010, en: 16'h0020, same: 1'b0, exp_a: 1,  exp_b: 1};
        tab[3] = '{sel: 2'd1, idx: 32'd1, st: 16'h0010, en: 16'h0020, same: 1'b1, exp_a: -1, exp_b: -1};
        tab[4] = '{sel: 2'd0, idx: 32'd0, st: 16'h3000, en: 16'h2000, same: 1'b0, exp_a: 0,  exp_b: -1};
        tab[5] = '{sel: 2'd2, idx: 32'd1, st: 16'h4000, en: 16'h4000, same: 1'b0, exp_a: 0,  exp_b: -1};
        tab[6] = '{sel: 2'd0, idx: 32'd0, st: 16'h0100, en: 16'h0200, same: 1'b0, exp_a: 2,  exp_b: -1};
        tab[7] = '{sel: 2'd2, idx: 32'd1, st: 16'h4000, en: 16'h0000, same: 1'b1, exp_a: -1, exp_b: -1};
        tab[8] = '{sel: 2'd2, idx: 32'd5, st: 16'h0000, en: 16'h0000, same: 1'b0, exp_a: 2,  exp_b: 2};
        tab[9] = '{sel: 2'd2, idx: 32'd0, st: 16'hFFFE, en: 16'hFFFF, same: 1'b0, exp_a: -1, exp_b: -1};

        rst_n        = 1'b0;
        wr_valid     = 1'b0;
        wr_sel       = '0;
        wr_idx       = '0;
        wr_start     = '0;
        wr_end       = '0;
        commit_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_inst(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // directed table: write (or write-with-commit) then commit
        for (int v = 0; v < 10; v++) begin
            if (!tab[v].same) do_write(tab[v].sel, tab[v].idx, tab[v].st, tab[v].en);
            do_commit(tab[v].same, 1'b0, tab[v].sel, tab[v].idx, tab[v].st, tab[v].en,
                      tab[v].exp_a, tab[v].exp_b);
        end

        // write held through a commit: blocked until IDLE, then lands
        do_commit(1'b0, 1'b1, 2'd1, 32'd0, 16'h0500, 16'h0600, -1, -1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        model_write(2'd1, 32'd0, 16'h0500, 16'h0600);
        for (int i = 0; i < 2; i++) chk1("wr_error_held", i, wr_error[i], 1'b0);
        do_commit(1'b0, 1'b0, '0, '0, '0, '0, -2, -2);

        // out-of-range slot: handshaken, dropped, single error pulse
        do_write(2'd3, 32'd1, 16'h1234, 16'h5678);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk1("wr_error_single", i, wr_error[i], 1'b0);
        do_commit(1'b0, 1'b0, '0, '0, '0, '0, -2, -2);

        // reset while checking: abort without pulses
        @(negedge clk);
        commit_valid = 1'b1;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        for (int i = 0; i < 2; i++) chk1("ongoing_mid", i, ongoing[i], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) check_inst(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (NR + 2) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) check_inst(i, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // randomized writes and commits against the model
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                do_write(SW'($urandom_range(0, 3)), 32'($urandom_range(0, 2)),
                         AW'($urandom_range(0, 16'hFFFF)),
                         ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 16'hFFFF)));
            end
            do_commit(1'($urandom_range(0, 1)), 1'b0, SW'($urandom_range(0, 3)),
                      32'($urandom_range(0, 2)), AW'($urandom_range(0, 16'hFFFF)),
                      ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(0, 16'hFFFF)),
                      -2, -2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
